// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage: IF/ID pipeline stage with a 2-entry skid buffer, field pre-decode and a bubble counter
module ifid_skid_stage #(
    parameter int          BPU_IDX_W = 5,
    parameter int          BPU_PC_W  = 32,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_instr,
    input  logic [BPU_PC_W-1:0]  in_bpu_pc,
    input  logic [BPU_IDX_W-1:0] in_bpu_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_pc_4,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_jaddr,
    output logic [15:0]          id_imm,
    output logic [4:0]           id_shamt,
    output logic [4:0]           id_rs_addr,
    output logic [4:0]           id_rt_addr,
    output logic [4:0]           id_rd_addr,
    output logic [BPU_PC_W-1:0]  id_bpu_pc,
    output logic [BPU_IDX_W-1:0] id_bpu_idx,
    output logic [CNT_W-1:0]     bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state;
    logic [31:0] m_pc, m_instr, s_pc, s_instr;
    logic [BPU_PC_W-1:0] m_bpu_pc, s_bpu_pc;
    logic [BPU_IDX_W-1:0] m_bpu_idx, s_bpu_idx;
    logic accept, fire, load_main_in, load_main_skid, load_skid;
    assign in_ready  = state != FULL;
    assign out_valid = state != EMPTY;
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;
    // Loads are suppressed by flush so a flushed cycle never changes held data.
    assign load_main_in   = !flush && accept && (state == EMPTY || (state == ONE && fire));
    assign load_main_skid = !flush && state == FULL && fire;
    assign load_skid      = !flush && state == ONE && accept && !fire;
    // Occupancy tracking; flush overrides any handshake in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else if (flush) state <= EMPTY;
        else begin
            case (state)
                EMPTY:   state <= accept ? ONE : EMPTY;
                ONE:     state <= (accept && !fire) ? FULL : (!accept && fire) ? EMPTY : ONE;
                FULL:    state <= fire ? ONE : FULL;
                default: state <= EMPTY;
            endcase
        end
    end
    // Head entry: loads from fetch directly or promotes the skid entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc      <= '0;
            m_instr   <= '0;
            m_bpu_pc  <= '0;
            m_bpu_idx <= '0;
        end else if (load_main_in) begin
            m_pc      <= in_pc;
            m_instr   <= in_instr;
            m_bpu_pc  <= in_bpu_pc;
            m_bpu_idx <= in_bpu_idx;
        end else if (load_main_skid) begin
            m_pc      <= s_pc;
            m_instr   <= s_instr;
            m_bpu_pc  <= s_bpu_pc;
            m_bpu_idx <= s_bpu_idx;
        end
    end
    // Skid entry catches the accept that arrives while the head is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_pc      <= '0;
            s_instr   <= '0;
            s_bpu_pc  <= '0;
            s_bpu_idx <= '0;
        end else if (load_skid) begin
            s_pc      <= in_pc;
            s_instr   <= in_instr;
            s_bpu_pc  <= in_bpu_pc;
            s_bpu_idx <= in_bpu_idx;
        end
    end
    // Saturating count of cycles where decode was ready but had nothing to take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bubble_cnt <= '0;
        else if (out_ready && !out_valid && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
    assign id_pc      = out_valid ? m_pc : '0;
    assign id_instr   = out_valid ? m_instr : NOP_INSTR;
    assign id_bpu_pc  = out_valid ? m_bpu_pc : '0;
    assign id_bpu_idx = out_valid ? m_bpu_idx : '0;
    assign id_pc_4    = id_pc + 32'd4;
    assign id_jaddr   = {id_pc[31:28], id_instr[25:0], 2'b00};
    assign id_imm     = id_instr[15:0];
    assign id_shamt   = id_instr[10:6];
    assign id_rs_addr = id_instr[25:21];
    assign id_rt_addr = id_instr[20:16];
    assign id_rd_addr = id_instr[15:11];
endmodule

// File: tb/tb_ifid_skid_stage.sv
// tb_ifid_skid_stage: directed scenario tests for the IF/ID skid stage
module tb_ifid_skid_stage;
    localparam logic [31:0] NOP = 32'h0000_0020;
    logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [31:0] in_pc = 0, in_instr = 0, in_bpu_pc = 0;
    logic [4:0] in_bpu_idx = 0;
    logic [31:0] id_pc, id_pc_4, id_instr, id_jaddr, id_bpu_pc;
    logic [15:0] id_imm;
    logic [4:0] id_shamt, id_rs_addr, id_rt_addr, id_rd_addr, id_bpu_idx;
    logic [3:0] bubble_cnt;
    int checks = 0, failures = 0;

    ifid_skid_stage #(.BPU_IDX_W(5), .BPU_PC_W(32), .CNT_W(4), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_bpu_pc(in_bpu_pc), .in_bpu_idx(in_bpu_idx),
        .out_valid(out_valid), .out_ready(out_ready), .id_pc(id_pc), .id_pc_4(id_pc_4),
        .id_instr(id_instr), .id_jaddr(id_jaddr), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_bpu_pc(id_bpu_pc), .id_bpu_idx(id_bpu_idx), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] bpc, input logic [4:0] bidx);
        in_valid = v; in_pc = pc; in_instr = ins; in_bpu_pc = bpc; in_bpu_idx = bidx;
    endtask

    task automatic test_reset();
        reset = 1;
        step(); step();
        reset = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (id_instr !== NOP) begin failures++; $display("FAIL reset_id_instr got=%h exp=%h", id_instr, NOP); end
        checks++; if (id_pc_4 !== 32'd4) begin failures++; $display("FAIL reset_id_pc_4 got=%h exp=4", id_pc_4); end
        checks++; if (id_jaddr !== 32'h0000_0080) begin failures++; $display("FAIL reset_id_jaddr got=%h exp=00000080", id_jaddr); end
        checks++; if (bubble_cnt !== 4'd0) begin failures++; $display("FAIL reset_bubble got=%0d exp=0", bubble_cnt); end
    endtask

    task automatic test_stream();
        out_ready = 1;
        drive(1, 32'h0040_0000, 32'h1111_0000, 32'hA000_0000, 5'd1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_pre_valid got=%0b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid0 got=%0b exp=1", out_valid); end
        checks++; if (id_pc !== 32'h0040_0000) begin failures++; $display("FAIL stream_pc0 got=%h exp=00400000", id_pc); end
        checks++; if (id_pc_4 !== 32'h0040_0004) begin failures++; $display("FAIL stream_pc4_0 got=%h exp=00400004", id_pc_4); end
        checks++; if (id_bpu_idx !== 5'd1) begin failures++; $display("FAIL stream_idx0 got=%0d exp=1", id_bpu_idx); end
        drive(1, 32'h0040_0004, 32'h1111_0004, 32'hA000_0004, 5'd2);
        step();
        checks++; if (id_pc !== 32'h0040_0004) begin failures++; $display("FAIL stream_pc1 got=%h exp=00400004", id_pc); end
        checks++; if (id_instr !== 32'h1111_0004) begin failures++; $display("FAIL stream_instr1 got=%h exp=11110004", id_instr); end
        drive(1, 32'h0040_0008, 32'h1111_0008, 32'hA000_0008, 5'd3);
        step();
        checks++; if (id_pc !== 32'h0040_0008) begin failures++; $display("FAIL stream_pc2 got=%h exp=00400008", id_pc); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready got=%0b exp=1", in_ready); end
        drive(0, 0, 0, 0, 0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
        checks++; if (bubble_cnt !== 4'd1) begin failures++; $display("FAIL stream_bubble got=%0d exp=1", bubble_cnt); end
        out_ready = 0;
    endtask

    task automatic test_backpressure();
        drive(1, 32'h0000_0A00, 32'hAAAA_0001, 32'h0000_0A0A, 5'd10);
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0b exp=1", in_ready); end
        drive(1, 32'h0000_0B00, 32'hBBBB_0002, 32'h0000_0B0B, 5'd11);
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%0b exp=0", in_ready); end
        checks++; if (id_pc !== 32'h0000_0A00) begin failures++; $display("FAIL bp_head_a got=%h exp=00000a00", id_pc); end
        drive(1, 32'h0000_0C00, 32'hCCCC_0003, 32'h0000_0C0C, 5'd12);
        step();
        checks++; if (id_instr !== 32'hAAAA_0001) begin failures++; $display("FAIL bp_hold_a got=%h exp=aaaa0001", id_instr); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready3 got=%0b exp=0", in_ready); end
        out_ready = 1;
        step();
        checks++; if (id_pc !== 32'h0000_0B00) begin failures++; $display("FAIL bp_head_b got=%h exp=00000b00", id_pc); end
        checks++; if (id_bpu_pc !== 32'h0000_0B0B) begin failures++; $display("FAIL bp_bpu_b got=%h exp=00000b0b", id_bpu_pc); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready4 got=%0b exp=1", in_ready); end
        step();
        checks++; if (id_pc !== 32'h0000_0C00) begin failures++; $display("FAIL bp_head_c got=%h exp=00000c00", id_pc); end
        checks++; if (id_bpu_idx !== 5'd12) begin failures++; $display("FAIL bp_idx_c got=%0d exp=12", id_bpu_idx); end
        drive(0, 0, 0, 0, 0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
        out_ready = 0;
        checks++; if (bubble_cnt !== 4'd1) begin failures++; $display("FAIL bp_bubble got=%0d exp=1", bubble_cnt); end
    endtask

    task automatic test_decode();
        drive(1, 32'h8000_0010, 32'h0C10_0003, 0, 0);
        step();
        checks++; if (id_jaddr !== 32'h8040_000C) begin failures++; $display("FAIL dec_jaddr got=%h exp=8040000c", id_jaddr); end
        checks++; if (id_rs_addr !== 5'd0) begin failures++; $display("FAIL dec_rs got=%0d exp=0", id_rs_addr); end
        checks++; if (id_rt_addr !== 5'd16) begin failures++; $display("FAIL dec_rt got=%0d exp=16", id_rt_addr); end
        checks++; if (id_imm !== 16'h0003) begin failures++; $display("FAIL dec_imm got=%h exp=0003", id_imm); end
        checks++; if (id_shamt !== 5'd0) begin failures++; $display("FAIL dec_shamt got=%0d exp=0", id_shamt); end
        drive(1, 32'hFFFF_FFFC, 32'h0003_1140, 0, 0);
        out_ready = 1;
        step();
        checks++; if (id_pc_4 !== 32'h0000_0000) begin failures++; $display("FAIL dec_pc4_wrap got=%h exp=00000000", id_pc_4); end
        checks++; if (id_jaddr !== 32'hF00C_4500) begin failures++; $display("FAIL dec_jaddr2 got=%h exp=f00c4500", id_jaddr); end
        checks++; if (id_rt_addr !== 5'd3) begin failures++; $display("FAIL dec_rt2 got=%0d exp=3", id_rt_addr); end
        checks++; if (id_rd_addr !== 5'd2) begin failures++; $display("FAIL dec_rd2 got=%0d exp=2", id_rd_addr); end
        checks++; if (id_shamt !== 5'd5) begin failures++; $display("FAIL dec_shamt2 got=%0d exp=5", id_shamt); end
        drive(1, 32'h0000_2000, 32'h012A_4820, 0, 0);
        step();
        checks++; if (id_rs_addr !== 5'd9) begin failures++; $display("FAIL dec_rs3 got=%0d exp=9", id_rs_addr); end
        checks++; if (id_imm !== 16'h4820) begin failures++; $display("FAIL dec_imm3 got=%h exp=4820", id_imm); end
        drive(0, 0, 0, 0, 0);
        step();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dec_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1, 32'h0000_0D00, 32'hDDDD_0000, 0, 0);
        step();
        drive(1, 32'h0000_0E00, 32'hEEEE_0000, 0, 0);
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_full got=%0b exp=0", in_ready); end
        drive(1, 32'h0000_0F00, 32'hFFFF_0000, 0, 0);
        flush = 1;
        step();
        flush = 0;
        drive(0, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", in_ready); end
        checks++; if (id_instr !== NOP) begin failures++; $display("FAIL flush_nop got=%h exp=%h", id_instr, NOP); end
        checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL flush_pc got=%h exp=0", id_pc); end
        step(); step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost got=%0b exp=0", out_valid); end
        out_ready = 1;
        step();
        out_ready = 0;
        checks++; if (bubble_cnt !== 4'd2) begin failures++; $display("FAIL flush_bubble got=%0d exp=2", bubble_cnt); end
    endtask

    task automatic test_async_reset();
        drive(1, 32'h0000_1100, 32'h1234_5678, 32'h5555_5555, 5'd7);
        step();
        drive(1, 32'h0000_1200, 32'h8765_4321, 32'h6666_6666, 5'd8);
        step();
        drive(0, 0, 0, 0, 0);
        #2 reset = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_ready got=%0b exp=1", in_ready); end
        checks++; if (id_instr !== NOP) begin failures++; $display("FAIL areset_nop got=%h exp=%h", id_instr, NOP); end
        checks++; if (id_bpu_pc !== 32'd0) begin failures++; $display("FAIL areset_bpu got=%h exp=0", id_bpu_pc); end
        checks++; if (bubble_cnt !== 4'd0) begin failures++; $display("FAIL areset_bubble got=%0d exp=0", bubble_cnt); end
        step();
        reset = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_after got=%0b exp=0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1;
        repeat (14) step();
        checks++; if (bubble_cnt !== 4'd14) begin failures++; $display("FAIL sat_14 got=%0d exp=14", bubble_cnt); end
        repeat (6) step();
        checks++; if (bubble_cnt !== 4'd15) begin failures++; $display("FAIL sat_15 got=%0d exp=15", bubble_cnt); end
        out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_decode();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifid_skid_stage.md
Name: ifid_skid_stage

Overview:
- Parametrised IF/ID pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
- Replaces the single stall/flush register between fetch and decode, so fetch and decode backpressure decouple without a combinational ready path.
- Carries PC, instruction and branch-predictor sideband.
- Pre-decodes instruction fields (rs/rt/rd/shamt/imm/jump target) and pc+4 for the ID stage.
- Adds a saturating bubble counter for performance monitoring.

Parameters:
- BPU_IDX_W, 5, width of the branch-predictor index sideband.
- BPU_PC_W, 32, width of the predicted-target sideband.
- CNT_W, 16, width of the bubble counter (saturating).
- NOP_INSTR, 32'h0000_0000, instruction word presented when the output is not valid.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  stage can accept an entry; registered, depends only on state.
- in_pc  input  32  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- in_bpu_pc  input  BPU_PC_W  predicted target from BPU.
- in_bpu_idx  input  BPU_IDX_W  BPU entry index.
- out_valid  output  1  decode-side entry valid.
- out_ready  input  1  decode consumes the entry this cycle.
- id_pc  output  32  head entry PC.
- id_pc_4  output  32  id_pc + 4, modulo 2^32.
- id_instr  output  32  head instruction, or NOP_INSTR when out_valid=0.
- id_jaddr  output  32  {id_pc[31:28], id_instr[25:0], 2'b00}.
- id_imm  output  16  id_instr[15:0].
- id_shamt  output  5  id_instr[10:6].
- id_rs_addr  output  5  id_instr[25:21].
- id_rt_addr  output  5  id_instr[20:16].
- id_rd_addr  output  5  id_instr[15:11].
- id_bpu_pc  output  BPU_PC_W  head entry sideband.
- id_bpu_idx  output  BPU_IDX_W  head entry sideband.
- bubble_cnt  output  CNT_W  count of cycles with out_ready=1 and out_valid=0.

Behaviour:
- Storage is a main entry (head, drives id_*) and a skid entry. State is EMPTY, ONE (main valid) or FULL (main and skid valid).
- Handshake: accept = in_valid & in_ready; fire = out_valid & out_ready.
- in_ready = (state != FULL). out_valid = (state != EMPTY). Both are functions of registered state only.
- Transitions when flush=0:
  - EMPTY: accept -> ONE, input loads main.
  - ONE: accept & fire -> ONE, main <= input. Accept only -> FULL, input loads skid. Fire only -> EMPTY.
  - FULL: fire -> ONE, main <= skid (no accept possible). Otherwise hold.
- Ordering: entries leave in acceptance order. No entry is dropped or duplicated without a flush.
- Latency: an entry accepted at edge N is visible on id_* in the cycle after edge N (one cycle) when the stage was EMPTY, or when ONE with a simultaneous fire.
- Flush has priority over everything in its cycle. Next state is EMPTY, and in_valid in the flush cycle is dropped, not accepted. A fire in the flush cycle still counts as consumed by decode. in_ready is 1 in the cycle after the flush.
- When out_valid=0:
  - id_instr = NOP_INSTR, and every derived field decodes from NOP_INSTR.
  - id_pc, id_bpu_pc and id_bpu_idx are 0, so id_pc_4 = 4.
- Data registers update only on load. Held values are stable under backpressure (out_ready=0).
- bubble_cnt:
  - Increments when out_ready=1 and out_valid=0, including the cycle after a flush.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Reset (asynchronous, immediate):
  - state EMPTY, so out_valid=0 and in_ready=1.
  - All data registers 0, id_instr = NOP_INSTR, bubble_cnt = 0.
  - Reset mid-operation discards both entries with no partial update.
- After reset deasserts, the first edge may accept.

Test Plan:
- Reset then stream: in_valid=1 with pc 0x0040_0000, 0x0040_0004, 0x0040_0008, out_ready=1 -> out_valid rises one cycle after first accept. id_pc follows in order, id_pc_4 = 0x0040_0004 for the first entry, bubble_cnt = 1 (first cycle after reset) then constant.
- Backpressure: out_ready=0 while 3 entries offered -> two accepted, in_ready=0 after second. Release out_ready -> both emerge in order, third accepted once in_ready=1, no loss or duplication.
- Field decode: instr 0x0C10_0003 at pc 0x8000_0010 -> id_jaddr = 0x8040_000C, id_rs_addr = 0, id_imm = 0x0003, id_shamt = 0.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, id_instr = NOP_INSTR, in_ready=1, flush-cycle input never appears at the output.
- Asynchronous reset asserted mid-cycle while FULL -> outputs return to reset values before the next clock edge. bubble_cnt = 0.
- Saturation with CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt stops at 15.
